// File: rtl/tmr0_counter.sv
// TMR0 count register: synchronises the prescaler tick, counts it, flags overflow, handles CPU writes.
// Optional interrupt request output is built when the macro TMR0_IRQ_EN is defined.
module tmr0_counter #(
   parameter int WIDTH          = 8,
   parameter int SYNC_STAGES    = 2,
   parameter int INHIBIT_CYCLES = 2
) (
   input  logic             oscIn,
   input  logic             reset,
   input  logic             tick_in,
   input  logic             psa,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             t0if_clr,
`ifdef TMR0_IRQ_EN
   input  logic             t0ie,
   input  logic             gie,
   output logic             irq,
`endif
   output logic [WIDTH-1:0] tmr0_q,
   output logic             t0if,
   output logic             presc_clr
);

   typedef enum logic {
      ST_IDLE,
      ST_INHIBIT
   } state_t;

   localparam logic [2:0] INH_LOAD = 3'(INHIBIT_CYCLES);

   state_t           r_state;
   state_t           w_stateNext;
   logic [2:0]       r_inhCnt;
   logic [2:0]       w_inhCntNext;
   logic [SYNC_STAGES-1:0] r_sync;
   logic             r_hist;
   logic             w_inc;
   logic             w_incTake;
   logic             w_wrap;
   logic [WIDTH-1:0] r_tmr0;
   logic             r_t0if;
   logic             r_prescClr;

   assign w_inc = r_sync[SYNC_STAGES-1] & ~r_hist;

   // tick_in is asynchronous: resample it before edge detection.
   always_ff @(posedge oscIn or negedge reset) begin
      if (!reset) begin
         r_sync <= '0;
         r_hist <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], tick_in};
         r_hist <= r_sync[SYNC_STAGES-1];
      end
   end

   always_ff @(posedge oscIn or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_inhCnt <= '0;
      end else begin
         r_state  <= w_stateNext;
         r_inhCnt <= w_inhCntNext;
      end
   end

   // A write (re)opens the window; the cycle whose count reaches zero is the last dropped one.
   always_comb begin
      w_stateNext  = r_state;
      w_inhCntNext = r_inhCnt;
      if (wr_en) begin
         if (INHIBIT_CYCLES == 0) begin
            w_stateNext  = ST_IDLE;
            w_inhCntNext = '0;
         end else begin
            w_stateNext  = ST_INHIBIT;
            w_inhCntNext = INH_LOAD;
         end
      end else if (r_state == ST_INHIBIT) begin
         if (r_inhCnt <= 3'd1) begin
            w_stateNext  = ST_IDLE;
            w_inhCntNext = '0;
         end else begin
            w_inhCntNext = r_inhCnt - 3'd1;
         end
      end
   end

   assign w_incTake = w_inc & ~wr_en & (r_state == ST_IDLE);
   assign w_wrap    = w_incTake & (&r_tmr0);

   always_ff @(posedge oscIn or negedge reset) begin
      if (!reset) begin
         r_tmr0     <= '0;
         r_t0if     <= 1'b0;
         r_prescClr <= 1'b0;
      end else begin
         r_prescClr <= wr_en & ~psa;
         if (wr_en) begin
            r_tmr0 <= wr_data;
         end else if (w_incTake) begin
            r_tmr0 <= r_tmr0 + 1'b1;
         end
         if (w_wrap) begin
            r_t0if <= 1'b1;
         end else if (t0if_clr) begin
            r_t0if <= 1'b0;
         end
      end
   end

`ifdef TMR0_IRQ_EN
   logic r_irq;

   always_ff @(posedge oscIn or negedge reset) begin
      if (!reset) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= r_t0if & t0ie & gie;
      end
   end

   assign irq = r_irq;
`endif

   assign tmr0_q    = r_tmr0;
   assign t0if      = r_t0if;
   assign presc_clr = r_prescClr;

endmodule

// File: tb/tb_tmr0_counter.sv
// Self-checking bench for tmr0_counter: cycle model of count/overflow/write rules plus directed literal checks.
// Define TMR0_IRQ_EN to also exercise the interrupt output.
module tb_tmr0_counter;

   localparam int INH = 2;

   logic       oscIn   = 1'b0;
   logic       reset   = 1'b0;
   logic       tickIn  = 1'b0;
   logic       psa     = 1'b1;
   logic       wrEn    = 1'b0;
   logic [7:0] wrData  = 8'h00;
   logic       t0ifClr = 1'b0;
   logic [7:0] tmr0Q;
   logic       t0if;
   logic       prescClr;
`ifdef TMR0_IRQ_EN
   logic       t0ie = 1'b1;
   logic       gie  = 1'b1;
   logic       irq;
`endif

   int checks   = 0;
   int failures = 0;

   tmr0_counter #(.WIDTH(8), .SYNC_STAGES(2), .INHIBIT_CYCLES(INH)) dut (
      .oscIn     (oscIn),
      .reset     (reset),
      .tick_in   (tickIn),
      .psa       (psa),
      .wr_en     (wrEn),
      .wr_data   (wrData),
      .t0if_clr  (t0ifClr),
`ifdef TMR0_IRQ_EN
      .t0ie      (t0ie),
      .gie       (gie),
      .irq       (irq),
`endif
      .tmr0_q    (tmr0Q),
      .t0if      (t0if),
      .presc_clr (prescClr)
   );

   always #5 oscIn = ~oscIn;

   // Expected outputs. tick_in changes only at negedges, so each rising edge is
   // sampled on a known posedge k and lands in the count at posedge k+2.
   int         cyc       = 0;
   int         lastWrite = -1000;
   logic [7:0] mQ        = 8'h00;
   logic       mT0if     = 1'b0;
   logic       mPresc    = 1'b0;
   logic       mIrq      = 1'b0;
   logic [2:0] samples   = 3'b000;

   always @(posedge oscIn or negedge reset) begin : model
      int         now;
      logic       incDue;
      logic       wrapped;
      logic [7:0] nextQ;
      if (!reset) begin
         mQ        <= 8'h00;
         mT0if     <= 1'b0;
         mPresc    <= 1'b0;
         mIrq      <= 1'b0;
         samples   <= 3'b000;
         lastWrite <= -1000;
      end else begin
         now     = cyc + 1;
         incDue  = samples[1] && !samples[2];
         wrapped = 1'b0;
         nextQ   = mQ;
         if (wrEn) begin
            nextQ = wrData;
            lastWrite <= now;
         end else if (incDue && (now - lastWrite > INH)) begin
            wrapped = (mQ == 8'd255);
            nextQ   = 8'((int'(mQ) + 1) % 256);
         end
         mQ     <= nextQ;
         mPresc <= wrEn && !psa;
         if (wrapped) mT0if <= 1'b1;
         else if (t0ifClr) mT0if <= 1'b0;
`ifdef TMR0_IRQ_EN
         mIrq <= mT0if && t0ie && gie;
`endif
         samples <= {samples[1:0], tickIn};
         cyc     <= now;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge oscIn) begin
      checkOutput("cmp_tmr0_q", 32'(tmr0Q), 32'(mQ));
      checkOutput("cmp_t0if", 32'(t0if), 32'(mT0if));
      checkOutput("cmp_presc_clr", 32'(prescClr), 32'(mPresc));
`ifdef TMR0_IRQ_EN
      checkOutput("cmp_irq", 32'(irq), 32'(mIrq));
`endif
   end

   task automatic applyStimulus(input logic [7:0] data, input logic psaVal);
      @(negedge oscIn);
      wrEn   = 1'b1;
      wrData = data;
      psa    = psaVal;
      @(negedge oscIn);
      wrEn   = 1'b0;
   endtask

   task automatic applyTickPulse();
      @(negedge oscIn);
      tickIn = 1'b1;
      repeat (4) @(negedge oscIn);
      tickIn = 1'b0;
      repeat (3) @(negedge oscIn);
   endtask

   initial begin
      repeat (3) @(negedge oscIn);
      reset = 1'b1;
      repeat (2) @(negedge oscIn);

      // Asynchronous reset while inhibit is open and presc_clr is pulsing.
      applyStimulus(8'h37, 1'b0);
      checkOutput("pre_reset_q", 32'(tmr0Q), 32'h37);
      checkOutput("pre_reset_presc", 32'(prescClr), 32'h1);
      #2 reset = 1'b0;
      #1;
      checkOutput("async_reset_q", 32'(tmr0Q), 32'h0);
      checkOutput("async_reset_presc", 32'(prescClr), 32'h0);
      checkOutput("async_reset_t0if", 32'(t0if), 32'h0);
      @(negedge oscIn);
      reset = 1'b1;
      applyTickPulse();
      checkOutput("post_reset_idle_count", 32'(tmr0Q), 32'h1);

      applyStimulus(8'h00, 1'b1);
      repeat (2) @(negedge oscIn);
      for (int i = 0; i < 10; i++) applyTickPulse();
      checkOutput("count_ten", 32'(tmr0Q), 32'h0A);

      applyStimulus(8'hFE, 1'b1);
      repeat (2) @(negedge oscIn);
      applyTickPulse();
      checkOutput("ovf_ff", 32'(tmr0Q), 32'hFF);
      checkOutput("ovf_no_flag_yet", 32'(t0if), 32'h0);
      applyTickPulse();
      checkOutput("ovf_wrap_q", 32'(tmr0Q), 32'h00);
      checkOutput("ovf_wrap_flag", 32'(t0if), 32'h1);
`ifdef TMR0_IRQ_EN
      checkOutput("irq_set", 32'(irq), 32'h1);
      gie = 1'b0;
      @(negedge oscIn);
      checkOutput("irq_gie_drop", 32'(irq), 32'h0);
      gie = 1'b1;
`endif
      @(negedge oscIn);
      t0ifClr = 1'b1;
      @(negedge oscIn);
      t0ifClr = 1'b0;
      checkOutput("t0if_cleared", 32'(t0if), 32'h0);

      // Clear pulse placed on the same edge as the wrap.
      applyStimulus(8'hFF, 1'b1);
      repeat (2) @(negedge oscIn);
      tickIn = 1'b1;
      @(negedge oscIn);
      @(negedge oscIn);
      t0ifClr = 1'b1;
      @(negedge oscIn);
      t0ifClr = 1'b0;
      checkOutput("clr_vs_wrap_flag", 32'(t0if), 32'h1);
      checkOutput("clr_vs_wrap_q", 32'(tmr0Q), 32'h00);
      repeat (2) @(negedge oscIn);
      tickIn = 1'b0;
      repeat (4) @(negedge oscIn);

      // Increment landing d cycles after a write of 0x80.
      for (int d = 0; d < 4; d++) begin
         applyStimulus(8'h10, 1'b1);
         repeat (3) @(negedge oscIn);
         for (int t = 0; t < 10; t++) begin
            @(negedge oscIn);
            tickIn = (t >= 3 && t < 7);
            wrEn   = (t == 5 - d);
            wrData = 8'h80;
         end
         repeat (2) @(negedge oscIn);
         checkOutput($sformatf("inhibit_d%0d", d), 32'(tmr0Q), (d == 3) ? 32'h81 : 32'h80);
      end

      applyStimulus(8'h55, 1'b0);
      checkOutput("presc_pulse", 32'(prescClr), 32'h1);
      @(negedge oscIn);
      checkOutput("presc_one_cycle", 32'(prescClr), 32'h0);
      applyStimulus(8'h55, 1'b1);
      checkOutput("presc_psa_wdt", 32'(prescClr), 32'h0);
      @(negedge oscIn);
      checkOutput("presc_psa_wdt_next", 32'(prescClr), 32'h0);

      repeat (3) @(negedge oscIn);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
